idli_mem_ctl_m: RTL and testbench
=================================

IDLI_MEM_CTL_M -- requirements
Module: idli_mem_ctl_m

Interface
REQ-001 SHALL have a single clock and an asynchronous active-low reset.
REQ-002 SHALL have port i_mem_gck, input, 1 bit: clock, all state on rising edge.
REQ-003 SHALL have port i_mem_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port i_mem_if_req, input, 1 bit: instruction fetch request, held until granted.
REQ-005 SHALL have port i_mem_if_addr, input, 16 bits: fetch address.
REQ-006 SHALL have port i_mem_ls_req, input, 1 bit: load/store request, held until granted.
REQ-007 SHALL have port i_mem_ls_wr, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port i_mem_ls_addr, input, 16 bits: load/store address.
REQ-009 SHALL have port i_mem_ls_wdata, input, 16 bits: store data.
REQ-010 SHALL have port i_mem_sio_in, input, 4 bits: quad serial bus input nibble.
REQ-011 SHALL have port o_mem_cs_n, output, 1 bit: memory chip select, active low.
REQ-012 SHALL have port o_mem_sio_out, output, 4 bits: quad serial bus output nibble.
REQ-013 SHALL have port o_mem_sio_oe, output, 1 bit: bus output enable.
REQ-014 SHALL have ports o_mem_if_gnt and o_mem_ls_gnt, outputs, 1 bit each: one-cycle grant pulses.
REQ-015 SHALL have port o_mem_rd_data, output, 4 bits: read nibble, equal to i_mem_sio_in combinationally.
REQ-016 SHALL have ports o_mem_if_vld and o_mem_ls_vld, outputs, 1 bit each: o_mem_rd_data valid for fetch (decoder enc_vld) or load.
REQ-017 SHALL have port o_mem_done, output, 1 bit: one-cycle transaction-complete pulse.

Function
REQ-018 SHALL implement an FSM with states IDLE, CMD, ADDR, TA, DATA and END, plus a 2-bit nibble counter cleared on every state change.
REQ-019 In IDLE, cs_n=1 and oe=0; if any request is high, SHALL pulse exactly one grant, latch address, type and wdata, and go to CMD next cycle.
REQ-020 If both requests are high, SHALL grant the requester not granted last; the last-granted flag resets to LS, so IF wins the first contention.
REQ-021 Requests SHALL be sampled only in IDLE and ignored in all other states.
REQ-022 In CMD (2 cycles), cs_n=0 and oe=1; sio_out SHALL be 0x0 then 0x3 for a read (IF or load), or 0x0 then 0x2 for a store.
REQ-023 In ADDR (4 cycles), sio_out SHALL be the latched address nibbles, most significant first ([15:12] to [3:0]).
REQ-024 After ADDR, a read SHALL go to TA for 2 cycles (oe=0, cs_n=0); a store SHALL go directly to DATA.
REQ-025 In read DATA (4 cycles), oe=0 and o_mem_if_vld or o_mem_ls_vld (per granted requester) SHALL be 1 on each cycle, MSB nibble first.
REQ-026 In store DATA (4 cycles), oe=1 and sio_out SHALL be latched wdata nibbles, MSB first; both vld outputs SHALL stay 0.
REQ-027 END SHALL last 1 cycle with cs_n=1, oe=0 and o_mem_done=1, then return to IDLE.
REQ-028 Read timing with grant at cycle 0: CMD 1-2, ADDR 3-6, TA 7-8, DATA 9-12, END 13; next grant no earlier than cycle 14.
REQ-029 Store timing with grant at cycle 0: CMD 1-2, ADDR 3-6, DATA 7-10, END 11.
REQ-030 sio_out SHALL be 0x0 whenever oe=0.
REQ-031 The grant and vld outputs of both requesters SHALL never be 1 in the same cycle.

Reset
REQ-032 Reset assertion SHALL immediately force cs_n=1, oe=0, sio_out=0x0, both grants, both vld outputs and done to 0, state to IDLE, counter to 0 and last-granted to LS, including mid-transaction.
REQ-033 Latched address and data registers SHALL not need a reset value.
REQ-034 After reset deassertion, the first grant SHALL occur on the first rising edge at which a request is high.

Verification
REQ-035 IF read of 0x1234 with sio_in 0xA,0xB,0xC,0xD in DATA -> sio_out 0,3,1,2,3,4; if_vld high cycles 9-12 with rd_data A,B,C,D; done at cycle 13.
REQ-036 Store to 0x00F0 of 0xBEEF -> sio_out 0,2,0,0,F,0,B,E,E,F with oe high cycles 1-10; done at cycle 11; no vld.
REQ-037 IF and LS requests high together from reset, held -> if_gnt first; ls_gnt at cycle 14; after that, if_gnt again, strictly alternating.
REQ-038 Reset asserted during ADDR -> cs_n=1 and oe=0 with no clock edge; after release with no request, bus stays idle.
REQ-039 Request raised during a transaction -> not granted before END; granted in the following IDLE cycle.

Source files
------------

// File: rtl/idli_mem_ctl_m.sv
// Quad-serial memory controller: arbitrates fetch and load/store requests
// and runs one command/address/data burst per granted access.
module idli_mem_ctl_m (
  input  logic        i_mem_gck,
  input  logic        i_mem_rst_n,
  input  logic        i_mem_if_req,
  input  logic [15:0] i_mem_if_addr,
  input  logic        i_mem_ls_req,
  input  logic        i_mem_ls_wr,
  input  logic [15:0] i_mem_ls_addr,
  input  logic [15:0] i_mem_ls_wdata,
  input  logic [3:0]  i_mem_sio_in,
  output logic        o_mem_cs_n,
  output logic [3:0]  o_mem_sio_out,
  output logic        o_mem_sio_oe,
  output logic        o_mem_if_gnt,
  output logic        o_mem_ls_gnt,
  output logic [3:0]  o_mem_rd_data,
  output logic        o_mem_if_vld,
  output logic        o_mem_ls_vld,
  output logic        o_mem_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_TA, S_DATA, S_END
  } state_t;

  state_t      state, nxt;
  logic [1:0]  cnt;
  logic        last_ls;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        wr;
  logic        is_if;
  logic        pick_if;
  logic        gnt_if;
  logic        gnt_ls;
  logic [1:0]  nib;

  // Grants are gated by reset so nothing is granted while it is held.
  assign pick_if = i_mem_if_req & (~i_mem_ls_req | last_ls);
  assign gnt_if  = i_mem_rst_n & (state == S_IDLE) & pick_if;
  assign gnt_ls  = i_mem_rst_n & (state == S_IDLE)
                 & i_mem_ls_req & ~pick_if;

  always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
    if (!i_mem_rst_n) begin
      state   <= S_IDLE;
      cnt     <= 2'd0;
      last_ls <= 1'b1;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? 2'd0 : cnt + 2'd1;
      if (gnt_if | gnt_ls)
        last_ls <= gnt_ls;
    end
  end

  always_ff @(posedge i_mem_gck) begin
    if (gnt_if | gnt_ls) begin
      addr  <= gnt_if ? i_mem_if_addr : i_mem_ls_addr;
      wdata <= i_mem_ls_wdata;
      wr    <= gnt_ls & i_mem_ls_wr;
      is_if <= gnt_if;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (gnt_if | gnt_ls) nxt = S_CMD;
      S_CMD:  if (cnt == 2'd1) nxt = S_ADDR;
      S_ADDR: if (cnt == 2'd3) nxt = wr ? S_DATA : S_TA;
      S_TA:   if (cnt == 2'd1) nxt = S_DATA;
      S_DATA: if (cnt == 2'd3) nxt = S_END;
      S_END:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Nibbles go out most significant first.
  assign nib = ~cnt;

  always_comb begin
    o_mem_cs_n    = 1'b1;
    o_mem_sio_oe  = 1'b0;
    o_mem_sio_out = 4'h0;
    o_mem_if_vld  = 1'b0;
    o_mem_ls_vld  = 1'b0;
    o_mem_done    = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_CMD: begin
        o_mem_cs_n   = 1'b0;
        o_mem_sio_oe = 1'b1;
        if (cnt[0])
          o_mem_sio_out = wr ? 4'h2 : 4'h3;
      end
      S_ADDR: begin
        o_mem_cs_n    = 1'b0;
        o_mem_sio_oe  = 1'b1;
        o_mem_sio_out = addr[{nib, 2'b00} +: 4];
      end
      S_TA: o_mem_cs_n = 1'b0;
      S_DATA: begin
        o_mem_cs_n = 1'b0;
        if (wr) begin
          o_mem_sio_oe  = 1'b1;
          o_mem_sio_out = wdata[{nib, 2'b00} +: 4];
        end else begin
          o_mem_if_vld = is_if;
          o_mem_ls_vld = ~is_if;
        end
      end
      S_END: o_mem_done = 1'b1;
      default: ;
    endcase
  end

  assign o_mem_if_gnt  = gnt_if;
  assign o_mem_ls_gnt  = gnt_ls;
  assign o_mem_rd_data = i_mem_sio_in;

endmodule

// File: tb/tb_idli_mem_ctl_m.sv
// Bench for idli_mem_ctl_m: per-cycle transaction model plus
// directed scenarios with literal expectations.
module tb_idli_mem_ctl_m;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        ls_req;
  logic        ls_wr;
  logic [15:0] ls_addr;
  logic [15:0] ls_wdata;
  logic [3:0]  sio_in;
  logic        cs_n;
  logic [3:0]  sio_out;
  logic        sio_oe;
  logic        if_gnt;
  logic        ls_gnt;
  logic [3:0]  rd_data;
  logic        if_vld;
  logic        ls_vld;
  logic        done;

  always #5 clk = ~clk;

  idli_mem_ctl_m dut (
    .i_mem_gck      (clk),
    .i_mem_rst_n    (rst_n),
    .i_mem_if_req   (if_req),
    .i_mem_if_addr  (if_addr),
    .i_mem_ls_req   (ls_req),
    .i_mem_ls_wr    (ls_wr),
    .i_mem_ls_addr  (ls_addr),
    .i_mem_ls_wdata (ls_wdata),
    .i_mem_sio_in   (sio_in),
    .o_mem_cs_n     (cs_n),
    .o_mem_sio_out  (sio_out),
    .o_mem_sio_oe   (sio_oe),
    .o_mem_if_gnt   (if_gnt),
    .o_mem_ls_gnt   (ls_gnt),
    .o_mem_rd_data  (rd_data),
    .o_mem_if_vld   (if_vld),
    .o_mem_ls_vld   (ls_vld),
    .o_mem_done     (done)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  // Transaction model: index k counts cycles since the grant.
  bit          m_busy = 0;
  int          m_k = 0;
  bit          m_if = 0;
  bit          m_wr = 0;
  logic [15:0] m_addr = 0;
  logic [15:0] m_wdata = 0;
  bit          m_last_ls = 1;

  logic       o_if_gnt, o_ls_gnt, o_oe, o_cs, o_done, o_ifv, o_lsv;
  logic [3:0] o_sio, o_rd;

  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    logic       e_cs, e_oe, e_ig, e_lg, e_iv, e_lv, e_done;
    logic [3:0] e_sio;
    int         endk;
    e_cs = 1; e_oe = 0; e_sio = 0; e_ig = 0; e_lg = 0;
    e_iv = 0; e_lv = 0; e_done = 0;
    endk = m_wr ? 11 : 13;
    #1;
    o_if_gnt = if_gnt; o_ls_gnt = ls_gnt; o_oe = sio_oe;
    o_cs = cs_n; o_done = done; o_ifv = if_vld; o_lsv = ls_vld;
    o_sio = sio_out; o_rd = rd_data;
    if (!rst_n) begin
      m_busy = 0;
      m_last_ls = 1;
    end else if (!m_busy) begin
      e_ig = (if_req && ls_req) ? m_last_ls : if_req;
      e_lg = (if_req || ls_req) && !e_ig;
    end else begin
      if (m_k == endk) e_done = 1;
      else e_cs = 0;
      if (m_k <= 2) begin
        e_oe = 1;
        e_sio = (m_k == 1) ? 4'h0 : (m_wr ? 4'h2 : 4'h3);
      end else if (m_k <= 6) begin
        e_oe = 1;
        e_sio = 4'((m_addr >> (4 * (6 - m_k))) & 16'hF);
      end else if (m_wr && m_k <= 10) begin
        e_oe = 1;
        e_sio = 4'((m_wdata >> (4 * (10 - m_k))) & 16'hF);
      end else if (!m_wr && m_k >= 9 && m_k <= 12) begin
        if (m_if) e_iv = 1;
        else e_lv = 1;
      end
    end
    check("cs_n", o_cs, e_cs);
    check("oe", o_oe, e_oe);
    check("sio_out", o_sio, e_sio);
    check("if_gnt", o_if_gnt, e_ig);
    check("ls_gnt", o_ls_gnt, e_lg);
    check("if_vld", o_ifv, e_iv);
    check("ls_vld", o_lsv, e_lv);
    check("done", o_done, e_done);
    check("rd_data", o_rd, sio_in);
    if (rst_n) begin
      if (!m_busy && (e_ig || e_lg)) begin
        m_busy = 1;
        m_k = 1;
        m_if = e_ig;
        m_wr = e_lg && ls_wr;
        m_addr = e_ig ? if_addr : ls_addr;
        m_wdata = ls_wdata;
        m_last_ls = e_lg;
      end else if (m_busy) begin
        if (m_k == endk) m_busy = 0;
        else m_k++;
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] q[$];
  logic [3:0] rq[$];
  int gnt_at, done_at, vld_first, vld_cnt, oe_first, cs_low;
  int g_rel[$];
  bit g_ls[$];

  initial begin
    logic [3:0] exp_rd[4];
    logic [3:0] exp_st[10];
    logic [3:0] exp_ld[6];
    exp_ld = '{4'h0, 4'h3, 4'h1, 4'h2, 4'h3, 4'h4};
    exp_rd = '{4'hA, 4'hB, 4'hC, 4'hD};
    exp_st = '{4'h0, 4'h2, 4'h0, 4'h0, 4'hF, 4'h0,
               4'hB, 4'hE, 4'hE, 4'hF};
    rst_n = 0; if_req = 1; if_addr = 0; ls_req = 0; ls_wr = 0;
    ls_addr = 0; ls_wdata = 0; sio_in = 0;
    @(negedge clk);
    tick();
    #1;
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_oe", sio_oe, 1'b0);
    check("rst_sio", sio_out, 4'h0);
    check("rst_if_gnt", if_gnt, 1'b0);
    @(negedge clk);
    if_req = 0;
    rst_n = 1;
    tick();

    // IF read of 0x1234
    if_req = 1; if_addr = 16'h1234;
    q.delete(); rq.delete();
    gnt_at = -1; done_at = -1; vld_first = -1;
    for (int i = 0; i < 14; i++) begin
      sio_in = (i >= 9 && i <= 12) ? 4'(4'hA + i - 9) : 4'h5;
      tick();
      if (o_if_gnt) begin if_req = 0; gnt_at = i; end
      if (o_oe) q.push_back(o_sio);
      if (o_ifv) begin
        rq.push_back(o_rd);
        if (vld_first < 0) vld_first = i;
      end
      if (o_done) done_at = i;
    end
    check("rd_gnt_at", 16'(gnt_at), 16'd0);
    check("rd_oe_cnt", 16'(q.size()), 16'd6);
    for (int i = 0; i < 6 && i < q.size(); i++)
      check("rd_sio_seq", q[i], exp_ld[i]);
    check("rd_vld_cnt", 16'(rq.size()), 16'd4);
    for (int i = 0; i < 4 && i < rq.size(); i++)
      check("rd_data_seq", rq[i], exp_rd[i]);
    check("rd_vld_first", 16'(vld_first), 16'd9);
    check("rd_done_at", 16'(done_at), 16'd13);

    // Store 0xBEEF to 0x00F0
    ls_req = 1; ls_wr = 1; ls_addr = 16'h00F0; ls_wdata = 16'hBEEF;
    q.delete();
    done_at = -1; vld_cnt = 0; oe_first = -1; gnt_at = -1;
    for (int i = 0; i < 12; i++) begin
      sio_in = 4'(i);
      tick();
      if (o_ls_gnt) begin ls_req = 0; gnt_at = i; end
      if (o_oe) begin
        q.push_back(o_sio);
        if (oe_first < 0) oe_first = i;
      end
      if (o_ifv || o_lsv) vld_cnt++;
      if (o_done) done_at = i;
    end
    check("st_gnt_at", 16'(gnt_at), 16'd0);
    check("st_oe_cnt", 16'(q.size()), 16'd10);
    for (int i = 0; i < 10 && i < q.size(); i++)
      check("st_sio_seq", q[i], exp_st[i]);
    check("st_oe_first", 16'(oe_first), 16'd1);
    check("st_done_at", 16'(done_at), 16'd11);
    check("st_vld_cnt", 16'(vld_cnt), 16'd0);
    ls_wr = 0;

    // Contention from reset, both requests held
    rst_n = 0;
    if_req = 1; if_addr = 16'hC0DE;
    ls_req = 1; ls_addr = 16'h5A5A;
    tick();
    rst_n = 1;
    g_rel.delete(); g_ls.delete();
    for (int i = 0; i < 56; i++) begin
      sio_in = 4'($urandom_range(0, 15));
      tick();
      if (o_if_gnt || o_ls_gnt) begin
        g_rel.push_back(i);
        g_ls.push_back(o_ls_gnt);
      end
    end
    if_req = 0; ls_req = 0;
    check("arb_gnt_cnt", 16'(g_rel.size()), 16'd4);
    for (int i = 0; i < 4 && i < g_rel.size(); i++) begin
      check("arb_gnt_cycle", 16'(g_rel[i]), 16'(14 * i));
      check("arb_gnt_is_ls", 16'(g_ls[i]), 16'(i % 2));
    end
    for (int i = 0; i < 14; i++) tick();

    // Reset asserted during ADDR
    ls_req = 1; ls_addr = 16'h8421;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_ls_gnt) ls_req = 0;
    end
    #2 rst_n = 0;
    #1;
    check("mid_rst_cs_n", cs_n, 1'b1);
    check("mid_rst_oe", sio_oe, 1'b0);
    check("mid_rst_sio", sio_out, 4'h0);
    tick();
    rst_n = 1;
    cs_low = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!o_cs || o_oe) cs_low++;
    end
    check("post_rst_idle", 16'(cs_low), 16'd0);

    // Request raised while a store is in flight
    ls_req = 1; ls_wr = 1; ls_addr = 16'h0102; ls_wdata = 16'h3344;
    gnt_at = -1;
    for (int i = 0; i < 28; i++) begin
      if (i == 5) begin if_req = 1; if_addr = 16'h7777; end
      tick();
      if (o_ls_gnt) ls_req = 0;
      if (o_if_gnt) begin if_req = 0; gnt_at = i; end
    end
    check("late_if_gnt_at", 16'(gnt_at), 16'd12);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
